fc_weight_reader: RTL
=====================

# fc_weight_reader

Read-side sequencer for the SE-block fully-connected two-bank weight memory. Takes a job request (word count), drives `index`/`en`/`rd` into the memory in strictly linear order, and follows the memory's implicit bank switch (bank 1 → bank 2 → bank 1). Returns 32-lane weight words to the FC MAC array over a valid/ready stream, with a credit-limited output FIFO that absorbs the memory's 1-cycle read latency.

## Interface

Clock and reset: one clock; reset is synchronous and active-low (`clk`, `rst`).

Parameters:
- `HEIGHT_1` = 32768: bank 1 depth (words).
- `HEIGHT_2` = 1256: bank 2 depth (words).
- `BITSIZE` = 14: lane width.
- `LANES` = 32: lanes per word.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: job request pulse; sampled only in IDLE.
- `num_words` in 16: words in the job; sampled with `start`.
- `busy` out 1: high in STREAM or DRAIN.
- `done` out 1: one-cycle pulse after the last word handshakes.
- `mem_en` out 1: memory enable.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe; constant 0.
- `mem_index` out 15: memory row index.
- `mem_data` in BITSIZE*LANES: memory read data, valid 1 cycle after `mem_rd`.
- `w_data` out BITSIZE*LANES: weight word to the MAC array.
- `w_valid` out 1: `w_data` valid.
- `w_ready` in 1: MAC array accepts the word.
- `w_last` out 1: marks the final word of the job.

## Operation

- Global pointer `gptr` runs 0..HEIGHT_1+HEIGHT_2-1. `mem_index` = `gptr` if `gptr` < HEIGHT_1, else `gptr`-HEIGHT_1.
- After the last bank-2 word, `gptr` wraps to 0. `gptr` persists across jobs so it stays aligned with the memory's internal `mem_sel`; only `rst` clears it.
- States:
  - IDLE: if `start`=1 and `num_words`≠0, latch `remaining_issue` = `remaining_out` = `num_words` and go to STREAM. If `start`=1 and `num_words`=0, pulse `done` next cycle and stay in IDLE.
  - STREAM: issue one read per cycle while `credits` > 0 and `remaining_issue` > 0. When `remaining_issue` reaches 0, go to DRAIN.
  - DRAIN: wait for output handshakes. When the word with `remaining_out`=1 handshakes, go to IDLE and pulse `done`.
- Credit rule: `credits` = 2 − FIFO occupancy − reads in flight. FIFO depth is 2. The FIFO never overflows, and the memory cannot be stalled.
- An issue cycle drives `mem_en`=`mem_rd`=1 with the current `mem_index`, increments `gptr`, and decrements `remaining_issue`. On non-issue cycles `mem_en`=`mem_rd`=0 and `mem_index` holds.
- The data captured on the cycle after an issue is pushed into the FIFO. `w_data` is the FIFO head. `w_last` = 1 when the head is the last word of the job.
- `start` while `busy` is ignored.
- Simultaneous FIFO push and pop with occupancy 2 is legal; a pop frees a credit in the same cycle.

## Timing

- Reset values: `busy`=0, `done`=0, `mem_en`=0, `mem_rd`=0, `mem_wr`=0, `mem_index`=0, `w_valid`=0, `w_last`=0, `w_data`=0. Also `gptr`=0, FIFO empty, state IDLE.
- First `mem_rd` occurs in the cycle after `start`.
- First `w_valid` occurs 2 cycles after the first `mem_rd`: 1 cycle memory latency plus 1 cycle FIFO write.
- Throughput is 1 word per cycle when `w_ready`=1 continuously.
- `w_data`, `w_valid` and `w_last` are stable while `w_valid`=1 and `w_ready`=0.
- `done` is asserted the cycle after the last handshake. `busy` falls in the same cycle as `done`.
- Reset asserted mid-job: all state returns to reset values on the next edge, and in-flight read data is discarded.

## Configuration

- `FC_RD_PERF_EN` defined: adds output `stall_cnt` (32 bits). It counts cycles with `w_valid`=1 and `w_ready`=0, saturates at all-ones, and clears on `start` accepted in IDLE.
- Not defined: no `stall_cnt` port and no counter logic.

## Structure

- Package `fc_mem_pkg` holds:
  - `FC_HEIGHT_1`, `FC_HEIGHT_2`, `FC_BITSIZE`, `FC_LANES`.
  - `FC_TOTAL` = `FC_HEIGHT_1` + `FC_HEIGHT_2`.
  - The state enum `fc_rd_state_t` (IDLE, STREAM, DRAIN).
- Sub-module `fc_rd_fifo2`: 2-entry synchronous FIFO carrying {`last`, data}, exposing occupancy for credit computation.

## Test plan

- Reset, then `start` with `num_words`=4 and `w_ready`=1 → `mem_index` 0,1,2,3 on consecutive cycles. Four `w_valid` beats with `w_last` on the 4th; `done` 1 cycle later.
- Hold `w_ready`=0 during a job of 8 → at most 2 reads issued; `w_data` held stable. Release `w_ready` → all 8 words delivered in order.
- Job of 3 with preloaded `gptr`=HEIGHT_1−2 → `mem_index` 32766, 32767, 0; third word comes from bank 2.
- Job crossing `gptr`=FC_TOTAL−1 → `mem_index` 1254, 1255, 0, with `gptr` wrapping to 0.
- `num_words`=0 → no `mem_rd`, `done` pulses 1 cycle after `start`. Also `start` during `busy` → ignored.
- Assert `rst`=0 mid-job → all outputs return to reset values next cycle. A new job afterwards starts at `mem_index` 0.

Source files
------------

// File: rtl/fc_mem_pkg.sv
// rtl/fc_mem_pkg.sv - shared geometry, state type and pointer helper for the FC weight reader
package fc_mem_pkg;

    localparam int FC_HEIGHT_1 = 32768;
    localparam int FC_HEIGHT_2 = 1256;
    localparam int FC_BITSIZE  = 14;
    localparam int FC_LANES    = 32;
    localparam int FC_TOTAL    = FC_HEIGHT_1 + FC_HEIGHT_2;
    localparam int FC_GPTR_W   = 16;
    localparam int FC_IDX_W    = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } fc_rd_state_t;

    // Advance the global pointer, wrapping after the final bank-2 row so the
    // reader stays aligned with the memory's own bank select.
    function automatic logic [FC_GPTR_W-1:0] fc_gptr_next(
        input logic [FC_GPTR_W-1:0] g,
        input logic [FC_GPTR_W-1:0] last
    );
        return (g == last) ? '0 : g + 1'b1;
    endfunction

endpackage

// File: rtl/fc_rd_fifo2.sv
// rtl/fc_rd_fifo2.sv - two-entry synchronous FIFO carrying {last, data} with occupancy output
module fc_rd_fifo2 #(
    parameter int W = 449
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_occ;

    // Payload storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide at any fill level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wptr <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_data = r_mem[r_rptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fc_weight_reader.sv
// rtl/fc_weight_reader.sv - linear two-bank weight read sequencer with credit-limited output stream (optional FC_RD_PERF_EN stall counter)
module fc_weight_reader
    import fc_mem_pkg::*;
#(
    parameter int HEIGHT_1 = FC_HEIGHT_1,
    parameter int HEIGHT_2 = FC_HEIGHT_2,
    parameter int BITSIZE  = FC_BITSIZE,
    parameter int LANES    = FC_LANES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                num_words,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_en,
    output logic                       mem_rd,
    output logic                       mem_wr,
    output logic [FC_IDX_W-1:0]        mem_index,
    input  logic [BITSIZE*LANES-1:0]   mem_data,
    output logic [BITSIZE*LANES-1:0]   w_data,
    output logic                       w_valid,
    input  logic                       w_ready,
`ifdef FC_RD_PERF_EN
    output logic [31:0]                stall_cnt,
`endif
    output logic                       w_last
);

    localparam int DW = BITSIZE * LANES;
    localparam logic [FC_GPTR_W-1:0] GPTR_LAST = FC_GPTR_W'(HEIGHT_1 + HEIGHT_2 - 1);
    localparam logic [FC_GPTR_W-1:0] BANK2_BASE = FC_GPTR_W'(HEIGHT_1);

    fc_rd_state_t           r_state;
    logic [FC_GPTR_W-1:0]   r_gptr;
    logic [15:0]            r_rem_issue;
    logic [15:0]            r_rem_out;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_inflight;
    logic                   r_inflight_last;

    logic                   w_issue;
    logic                   w_pop;
    logic [1:0]             w_occ;
    logic [2:0]             w_used;
    logic [FC_GPTR_W-1:0]   w_idx_full;
    logic [DW:0]            w_head;

    // A slot is owed to every buffered word and every read still in the
    // memory pipeline; a pop this cycle returns its slot immediately.
    assign w_pop      = (w_occ != 2'd0) && w_ready;
    assign w_used     = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_issue    = (r_state == ST_STREAM) && (r_rem_issue != 16'd0)
                        && (w_used < (3'd2 + {2'b00, w_pop}));
    assign w_idx_full = (r_gptr < BANK2_BASE) ? r_gptr : (r_gptr - BANK2_BASE);

    assign mem_index = w_idx_full[FC_IDX_W-1:0];
    assign mem_en    = w_issue;
    assign mem_rd    = w_issue;
    assign mem_wr    = 1'b0;
    assign busy      = r_busy;
    assign done      = r_done;
    assign w_valid   = (w_occ != 2'd0);
    assign w_data    = w_valid ? w_head[DW-1:0] : '0;
    assign w_last    = w_valid & w_head[DW];

    fc_rd_fifo2 #(
        .W (DW + 1)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_data ({r_inflight_last, mem_data}),
        .o_data (w_head),
        .o_occ  (w_occ)
    );

    // Job sequencing: accept a request, issue linear reads, then wait for the final handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_gptr          <= '0;
            r_rem_issue     <= 16'd0;
            r_rem_out       <= 16'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rem_issue == 16'd1);
            if (w_issue) begin
                r_gptr      <= fc_gptr_next(r_gptr, GPTR_LAST);
                r_rem_issue <= r_rem_issue - 16'd1;
            end
            if (w_pop && (r_rem_out != 16'd0)) begin
                r_rem_out <= r_rem_out - 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_words != 16'd0) begin
                            r_rem_issue <= num_words;
                            r_rem_out   <= num_words;
                            r_busy      <= 1'b1;
                            r_state     <= ST_STREAM;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_issue && (r_rem_issue == 16'd1)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && (r_rem_out == 16'd1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FC_RD_PERF_EN
    logic [31:0] r_stall_cnt;

    // Back-pressure counter: saturating, restarted by each accepted request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stall_cnt <= 32'd0;
        end else if (w_valid && !w_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
